// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle control unit: FSM states,
// ALU operation codes, data-processing cmd values and ARM condition codes.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        EXECR,
        EXECI,
        ALUWB,
        BRANCH,
        UNDEF
    } mc_state_e;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_ORR = 3'd3;
    localparam logic [2:0] ALU_EOR = 3'd4;
    localparam logic [2:0] ALU_MOV = 3'd5;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_TST = 4'b1000;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // ARM condition evaluation on an NZCV nibble; the 1111 slot never passes.
    function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v, r;
        {n, z, c, v} = nzcv;
        r = 1'b0;
        case (cond)
            COND_EQ: r = z;
            COND_NE: r = ~z;
            COND_CS: r = c;
            COND_CC: r = ~c;
            COND_MI: r = n;
            COND_PL: r = ~n;
            COND_VS: r = v;
            COND_VC: r = ~v;
            COND_HI: r = c & ~z;
            COND_LS: r = ~c | z;
            COND_GE: r = (n == v);
            COND_LT: r = (n != v);
            COND_GT: r = ~z & (n == v);
            COND_LE: r = z | (n != v);
            COND_AL: r = 1'b1;
            COND_NV: r = 1'b0;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mc_controller_cond_logic.sv
// NZCV flag register and condition evaluation for the multicycle controller.
module cond_logic
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       flag_en,
    output logic       CondEx,
    output logic [3:0] Flags
);

    logic [3:0] flags_q;

    // NZ and CV are written independently so logical ops keep the carry/overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= 4'b0000;
        end else if (flag_en) begin
            if (FlagW[1]) flags_q[3:2] <= ALUFlags[3:2];
            if (FlagW[0]) flags_q[1:0] <= ALUFlags[1:0];
        end
    end

    assign CondEx = cond_eval(Cond, flags_q);
    assign Flags  = flags_q;

endmodule

// File: rtl/mc_controller.sv
// Multicycle control unit: Moore FSM sequencing, ALU decode, condition gating
// of the datapath write enables.
module mc_controller
    import mc_ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W = 3,
    parameter bit EXT_LOGIC  = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            Cond,
    input  logic [1:0]            Op,
    input  logic [5:0]            Funct,
    input  logic [3:0]            Rd,
    input  logic [3:0]            ALUFlags,
    output logic                  PCWrite,
    output logic                  MemWrite,
    output logic                  RegWrite,
    output logic                  IRWrite,
    output logic                  AdrSrc,
    output logic                  ALUSrcA,
    output logic [1:0]            ALUSrcB,
    output logic [1:0]            ResultSrc,
    output logic [1:0]            ImmSrc,
    output logic [1:0]            RegSrc,
    output logic [ALU_CTRL_W-1:0] ALUControl,
    output logic [3:0]            Flags,
    output logic                  Undef,
    output mc_state_e             dbg_state
);

    mc_state_e  state, state_n;
    logic [3:0] cmd;
    logic       cmd_ok, cmd_nowrite, cmd_arith;
    logic [2:0] alu_op;
    logic       next_pc, reg_w, mem_w, branch, ir_w, undef_s, exec;
    logic       cond_ex, cond_q, nowrite_q, pcs;
    logic [1:0] flag_w;

    assign cmd = Funct[4:1];

    // Extended logical ops decode as illegal when EXT_LOGIC is off.
    always_comb begin
        cmd_ok      = 1'b1;
        cmd_nowrite = 1'b0;
        cmd_arith   = 1'b0;
        alu_op      = ALU_ADD;
        case (cmd)
            CMD_ADD: begin alu_op = ALU_ADD; cmd_arith = 1'b1; end
            CMD_SUB: begin alu_op = ALU_SUB; cmd_arith = 1'b1; end
            CMD_AND: alu_op = ALU_AND;
            CMD_ORR: alu_op = ALU_ORR;
            CMD_CMP: begin alu_op = ALU_SUB; cmd_arith = 1'b1; cmd_nowrite = 1'b1; end
            CMD_EOR: begin alu_op = ALU_EOR; cmd_ok = EXT_LOGIC; end
            CMD_MOV: begin alu_op = ALU_MOV; cmd_ok = EXT_LOGIC; end
            CMD_TST: begin alu_op = ALU_AND; cmd_nowrite = 1'b1; cmd_ok = EXT_LOGIC; end
            default: cmd_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= state_n;
    end

    always_comb begin
        state_n   = state;
        next_pc   = 1'b0;
        reg_w     = 1'b0;
        mem_w     = 1'b0;
        branch    = 1'b0;
        ir_w      = 1'b0;
        undef_s   = 1'b0;
        exec      = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        case (state)
            FETCH: begin
                state_n   = DECODE;
                ir_w      = 1'b1;
                next_pc   = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                case (Op)
                    OP_MEM:  state_n = MEMADR;
                    OP_BR:   state_n = BRANCH;
                    OP_DP:   state_n = !cmd_ok ? UNDEF : (Funct[5] ? EXECI : EXECR);
                    default: state_n = UNDEF;
                endcase
            end
            MEMADR: begin
                ALUSrcB = 2'b01;
                state_n = Funct[0] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                AdrSrc  = 1'b1;
                state_n = MEMWB;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                reg_w     = 1'b1;
                state_n   = FETCH;
            end
            MEMWR: begin
                AdrSrc  = 1'b1;
                mem_w   = 1'b1;
                state_n = FETCH;
            end
            EXECR: begin
                exec    = 1'b1;
                state_n = ALUWB;
            end
            EXECI: begin
                exec    = 1'b1;
                ALUSrcB = 2'b01;
                state_n = ALUWB;
            end
            ALUWB: begin
                reg_w   = 1'b1;
                state_n = FETCH;
            end
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                branch    = 1'b1;
                state_n   = FETCH;
            end
            UNDEF: begin
                undef_s = 1'b1;
                state_n = FETCH;
            end
            default: state_n = FETCH;
        endcase
    end

    // Condition and NoWrite are frozen at the end of DECODE for the rest of the instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            cond_q    <= 1'b0;
            nowrite_q <= 1'b0;
        end else if (state == DECODE) begin
            cond_q    <= cond_ex;
            nowrite_q <= (Op == OP_DP) & cmd_nowrite;
        end
    end

    assign flag_w = exec ? {Funct[0], Funct[0] & cmd_arith} : 2'b00;

    cond_logic u_cond (
        .clk      (clk),
        .reset    (reset),
        .Cond     (Cond),
        .ALUFlags (ALUFlags),
        .FlagW    (flag_w),
        .flag_en  (cond_q),
        .CondEx   (cond_ex),
        .Flags    (Flags)
    );

    assign ALUControl = exec ? ALU_CTRL_W'(alu_op) : '0;
    assign RegSrc     = {Op == OP_BR, (Op == OP_MEM) & ~Funct[0]};
    assign ImmSrc     = Op;

    // A register write to R15 is a PC write and must obey the condition too.
    assign pcs      = ((Rd == 4'hF) & reg_w) | branch;
    assign PCWrite  = ~reset & (next_pc | (pcs & cond_q));
    assign RegWrite = ~reset & reg_w & cond_q & ~nowrite_q;
    assign MemWrite = ~reset & mem_w & cond_q;
    assign IRWrite  = ~reset & ir_w;
    assign Undef    = ~reset & undef_s;

    assign dbg_state = state;

endmodule

// File: tb/tb_mc_controller.sv
// Randomized bench for mc_controller with a per-instruction reference model;
// one instance without and one with the extended logical ops.
module tb_mc_controller;
  import mc_ctrl_pkg::*;

  localparam int W = 3;
  localparam int C_LDR = 0, C_STR = 1, C_DP = 2, C_B = 3, C_UND = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]        rst;
  logic [1:0][3:0]   cond, rd, aluflags, flags;
  logic [1:0][1:0]   op, alusrcb, resultsrc, immsrc, regsrc;
  logic [1:0][5:0]   funct;
  logic [1:0]        pcwrite, memwrite, regwrite, irwrite, adrsrc, alusrca, undef;
  logic [1:0][W-1:0] aluctl;
  mc_state_e         st0, st1;

  int n_chk = 0;
  int n_err = 0;
  logic [3:0] mflags [2];
  logic       ext [2];
  logic [3:0] cmd_tab [8];

  mc_controller #(.ALU_CTRL_W(W), .EXT_LOGIC(1'b0)) u_dut0 (
    .clk(clk), .reset(rst[0]), .Cond(cond[0]), .Op(op[0]), .Funct(funct[0]), .Rd(rd[0]),
    .ALUFlags(aluflags[0]), .PCWrite(pcwrite[0]), .MemWrite(memwrite[0]), .RegWrite(regwrite[0]),
    .IRWrite(irwrite[0]), .AdrSrc(adrsrc[0]), .ALUSrcA(alusrca[0]), .ALUSrcB(alusrcb[0]),
    .ResultSrc(resultsrc[0]), .ImmSrc(immsrc[0]), .RegSrc(regsrc[0]), .ALUControl(aluctl[0]),
    .Flags(flags[0]), .Undef(undef[0]), .dbg_state(st0)
  );

  mc_controller #(.ALU_CTRL_W(W), .EXT_LOGIC(1'b1)) u_dut1 (
    .clk(clk), .reset(rst[1]), .Cond(cond[1]), .Op(op[1]), .Funct(funct[1]), .Rd(rd[1]),
    .ALUFlags(aluflags[1]), .PCWrite(pcwrite[1]), .MemWrite(memwrite[1]), .RegWrite(regwrite[1]),
    .IRWrite(irwrite[1]), .AdrSrc(adrsrc[1]), .ALUSrcA(alusrca[1]), .ALUSrcB(alusrcb[1]),
    .ResultSrc(resultsrc[1]), .ImmSrc(immsrc[1]), .RegSrc(regsrc[1]), .ALUControl(aluctl[1]),
    .Flags(flags[1]), .Undef(undef[1]), .dbg_state(st1)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic holds(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic cmd_info(input logic [3:0] cmd, input logic e, output logic ok,
                          output logic [2:0] code, output logic nowr, output logic arith);
    ok = 1'b1; code = 3'd0; nowr = 1'b0; arith = 1'b0;
    case (cmd)
      4'b0100: begin code = 3'd0; arith = 1'b1; end
      4'b0010: begin code = 3'd1; arith = 1'b1; end
      4'b0000: code = 3'd2;
      4'b1100: code = 3'd3;
      4'b1010: begin code = 3'd1; arith = 1'b1; nowr = 1'b1; end
      4'b0001: begin code = 3'd4; ok = e; end
      4'b1101: begin code = 3'd5; ok = e; end
      4'b1000: begin code = 3'd2; nowr = 1'b1; ok = e; end
      default: ok = 1'b0;
    endcase
  endtask

  // {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc} for cycle k of an instruction
  function automatic logic [5:0] exp_sels(input int cls, input int k, input logic imm);
    if (k < 2) return 6'b0_1_10_10;
    case (cls)
      C_LDR:   return (k == 2) ? 6'b0_0_01_00 : (k == 3) ? 6'b1_0_00_00 : 6'b0_0_00_01;
      C_STR:   return (k == 2) ? 6'b0_0_01_00 : 6'b1_0_00_00;
      C_DP:    return (k == 2 && imm) ? 6'b0_0_01_00 : 6'b0;
      C_B:     return 6'b0_0_01_10;
      default: return 6'b0;
    endcase
  endfunction

  // {PCWrite, MemWrite, RegWrite, IRWrite, Undef}
  function automatic logic [4:0] exp_writes(input int cls, input int k, input logic pass,
                                            input logic r15, input logic nowr);
    if (k == 0) return 5'b10010;
    if (cls == C_LDR && k == 4) return {pass & r15, 1'b0, pass, 2'b00};
    if (cls == C_STR && k == 3) return {1'b0, pass, 3'b000};
    if (cls == C_DP  && k == 3) return {pass & r15, 1'b0, pass & ~nowr, 2'b00};
    if (cls == C_B   && k == 2) return {pass, 4'b0000};
    if (cls == C_UND && k == 2) return 5'b00001;
    return 5'b00000;
  endfunction

  function automatic mc_state_e state_of(input int d);
    return (d == 0) ? st0 : st1;
  endfunction

  task automatic run_instr(input int d, input logic [3:0] c, input logic [1:0] o,
                           input logic [5:0] f, input logic [3:0] r, input int af);
    int cls, len;
    logic pass, ok, nowr, arith;
    logic [2:0] code;
    logic [3:0] afv;
    string tag;
    cmd_info(f[4:1], ext[d], ok, code, nowr, arith);
    if (o == 2'b01)              cls = f[0] ? C_LDR : C_STR;
    else if (o == 2'b10)         cls = C_B;
    else if (o == 2'b00 && ok)   cls = C_DP;
    else                         cls = C_UND;
    len = (cls == C_LDR) ? 5 : (cls == C_STR || cls == C_DP) ? 4 : 3;
    pass = holds(c, mflags[d]);
    cond[d] = c; op[d] = o; funct[d] = f; rd[d] = r;
    for (int k = 0; k < len; k++) begin
      afv = (af >= 0 && k == 2) ? 4'(af) : 4'($urandom_range(0, 15));
      aluflags[d] = afv;
      #4;
      tag = $sformatf("d%0d op%0d f%02h k%0d", d, o, f, k);
      check_eq({tag, " writes"},
               {27'd0, pcwrite[d], memwrite[d], regwrite[d], irwrite[d], undef[d]},
               {27'd0, exp_writes(cls, k, pass, r == 4'hF, nowr)});
      check_eq({tag, " sels"}, {26'd0, adrsrc[d], alusrca[d], alusrcb[d], resultsrc[d]},
               {26'd0, exp_sels(cls, k, f[5])});
      check_eq({tag, " regsrc_immsrc"}, {28'd0, regsrc[d], immsrc[d]},
               {28'd0, o == 2'b10, o == 2'b01 && !f[0], o});
      check_eq({tag, " aluctl"}, 32'(aluctl[d]), (cls == C_DP && k == 2) ? 32'(code) : 32'd0);
      check_eq({tag, " flags"}, 32'(flags[d]), 32'(mflags[d]));
      if (cls == C_DP && k == 2 && pass) begin
        if (f[0])          mflags[d][3:2] = afv[3:2];
        if (f[0] && arith) mflags[d][1:0] = afv[1:0];
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic reset_mid_ldr(input int d);
    cond[d] = 4'hE; op[d] = 2'b01; funct[d] = 6'b011001; rd[d] = 4'h5;
    for (int k = 0; k < 3; k++) begin
      aluflags[d] = 4'($urandom_range(0, 15));
      @(posedge clk); #1;
    end
    check_eq($sformatf("d%0d ldr reaches memrd", d), 32'(state_of(d)), 32'(MEMRD));
    rst[d] = 1'b1;
    #4;
    check_eq($sformatf("d%0d reset writes", d),
             {27'd0, pcwrite[d], memwrite[d], regwrite[d], irwrite[d], undef[d]}, 32'd0);
    @(posedge clk); #1;
    rst[d] = 1'b0;
    mflags[d] = 4'b0000;
    check_eq($sformatf("d%0d fetch after reset", d), 32'(state_of(d)), 32'(FETCH));
  endtask

  task automatic run_phase(input int d);
    logic [1:0] o;
    logic [5:0] f;
    logic [3:0] c, r;
    #4;
    check_eq($sformatf("d%0d reset state", d), 32'(state_of(d)), 32'(FETCH));
    check_eq($sformatf("d%0d reset writes", d),
             {27'd0, pcwrite[d], memwrite[d], regwrite[d], irwrite[d], undef[d]}, 32'd0);
    check_eq($sformatf("d%0d reset flags", d), 32'(flags[d]), 32'd0);
    @(posedge clk); #1;
    rst[d] = 1'b0;
    mflags[d] = 4'b0000;
    run_instr(d, 4'hE, 2'b00, 6'b101001, 4'h1, 4'b0100);  // ADDS, Z result
    run_instr(d, 4'h0, 2'b10, 6'b100000, 4'h0, -1);       // BEQ taken
    run_instr(d, 4'h1, 2'b10, 6'b100000, 4'h0, -1);       // BNE not taken
    run_instr(d, 4'hE, 2'b01, 6'b011000, 4'h2, -1);       // STR
    run_instr(d, 4'hE, 2'b01, 6'b011001, 4'hF, -1);       // LDR PC
    run_instr(d, 4'hE, 2'b00, 6'b010101, 4'h3, 4'b1001);  // CMP
    run_instr(d, 4'hE, 2'b00, 6'b000010, 4'h4, -1);       // EOR
    run_instr(d, 4'hE, 2'b00, 6'b111010, 4'h5, -1);       // MOV imm
    run_instr(d, 4'hE, 2'b00, 6'b010001, 4'h6, 4'b0110);  // TST
    run_instr(d, 4'hE, 2'b11, 6'b000000, 4'h7, -1);       // Op=11
    run_instr(d, 4'hF, 2'b00, 6'b101001, 4'h1, -1);       // never-condition ADDS
    run_instr(d, 4'hE, 2'b00, 6'b101001, 4'h1, 4'b1111);
    reset_mid_ldr(d);
    for (int i = 0; i < 120; i++) begin
      o = 2'($urandom_range(0, 3));
      f = 6'($urandom);
      if ($urandom_range(0, 3) != 0) f[4:1] = cmd_tab[$urandom_range(0, 7)];
      c = ($urandom_range(0, 2) == 0) ? 4'hE : 4'($urandom_range(0, 15));
      r = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      run_instr(d, c, o, f, r, -1);
    end
    rst[d] = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 2'b11;
    cond = '0; rd = '0; aluflags = '0; op = '0; funct = '0;
    mflags[0] = 4'b0000; mflags[1] = 4'b0000;
    ext[0] = 1'b0; ext[1] = 1'b1;
    cmd_tab[0] = 4'b0100; cmd_tab[1] = 4'b0010; cmd_tab[2] = 4'b0000; cmd_tab[3] = 4'b1100;
    cmd_tab[4] = 4'b1010; cmd_tab[5] = 4'b0001; cmd_tab[6] = 4'b1101; cmd_tab[7] = 4'b1000;
    repeat (2) @(posedge clk);
    #1;
    run_phase(0);
    run_phase(1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle control unit for the ARM-subset processor: the sequential successor of the single-cycle decoder. Sequences each instruction through a Moore FSM (fetch, decode, execute, memory, writeback), holds the NZCV flags and evaluates condition codes, and drives the shared-datapath selects and write enables. It sits between the instruction register/ALU flags and the multicycle datapath. It is parametrised in ALU-control width and in whether the extended logical operations are supported.

## Interface
- ALU_CTRL_W, 3, width of ALUControl; must be >= 3.
- EXT_LOGIC, 1, when 1, EOR/MOV/TST are decoded; when 0 they are treated as undefined.
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- Cond  in  4  instruction bits [31:28].
- Op  in  2  instruction bits [27:26].
- Funct  in  6  instruction bits [25:20].
- Rd  in  4  instruction bits [15:12].
- ALUFlags  in  4  NZCV from the ALU in the current cycle.
- PCWrite, MemWrite, RegWrite, IRWrite  out  1 each  datapath write enables.
- AdrSrc, ALUSrcA  out  1 each  address and ALU-A selects.
- ALUSrcB, ResultSrc, ImmSrc, RegSrc  out  2 each  datapath selects.
- ALUControl  out  ALU_CTRL_W  ALU operation.
- Flags  out  4  registered NZCV.
- Undef  out  1  high for one cycle in state UNDEF.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, UNDEF.
- FETCH → DECODE. MEMADR → MEMRD if Funct[0], else MEMWR. MEMRD → MEMWB → FETCH. MEMWR → FETCH. EXECR/EXECI → ALUWB → FETCH. BRANCH → FETCH. UNDEF → FETCH.
- DECODE transitions:
  - Op=01 → MEMADR.
  - Op=10 → BRANCH.
  - Op=00 with an implemented cmd → EXECI if Funct[5], else EXECR.
  - Op=11 or an unimplemented cmd → UNDEF.
- Per-state outputs; any select not listed is 0:
  - FETCH: IRWrite=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, NextPC=1.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - MEMADR and EXECI: ALUSrcB=01.
  - MEMRD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWR: AdrSrc=1, MemW=1.
  - ALUWB: RegW=1.
  - BRANCH: ALUSrcB=01, ResultSrc=10, Branch=1.
- RegSrc and ImmSrc decode combinationally from Op/Funct in every state:
  - RegSrc = {Op==10, Op==01 & ~Funct[0]}.
  - ImmSrc = Op.
- ALU decode. ALUControl encodings are 0 ADD, 1 SUB, 2 AND, 3 ORR, 4 EOR, 5 MOV, zero-extended to ALU_CTRL_W. ALUControl is 0 outside EXECR/EXECI. The cmd field is Funct[4:1]:
  - 0100 ADD; 0010 SUB; 0000 AND; 1100 ORR.
  - 1010 CMP: SUB with NoWrite.
  - 0001 EOR, 1101 MOV, 1000 TST (AND with NoWrite): only when EXT_LOGIC=1.
- FlagW[1] (NZ) = Funct[0]; FlagW[0] (CV) = Funct[0] & (ADD|SUB|CMP). FlagW is active only in EXECR/EXECI.
- Condition: CondEx is the ARM condition evaluated on the registered Flags (EQ…AL; 1111 evaluates false). CondEx is latched into cond_q at the end of DECODE.
- Gating:
  - PCS = (Rd==1111 & RegW) | Branch.
  - PCWrite = NextPC | (PCS & cond_q).
  - RegWrite = RegW & cond_q & ~NoWrite.
  - MemWrite = MemW & cond_q.

## Timing
- Latencies in cycles:
  - LDR: 5.
  - STR: 4.
  - Data-processing: 4.
  - B: 3.
  - Undefined instruction: 3.
- Flags update at the end of EXECR/EXECI when cond_q is high: NZ when FlagW[1], CV when FlagW[0]. The next instruction's DECODE sees the new flags.
- Reset (any cycle, including mid-instruction):
  - Next state is FETCH.
  - Flags, cond_q, and NoWrite are cleared.
  - PCWrite, MemWrite, RegWrite, IRWrite, and Undef are forced 0 while reset is high.
  - First fetch happens in the cycle after reset deasserts.
- Unconditional writes (those not gated by cond_q) occur only in FETCH (IRWrite, PCWrite).
- A failed condition still walks every state of the instruction; only its writes are suppressed.

## Structure
- Package mc_ctrl_pkg holds:
  - The state enum.
  - ALU encoding constants.
  - cmd field constants.
  - Condition-code constants.
- Sub-module cond_logic holds the flags register and condition evaluation: Cond, ALUFlags, FlagW, cond_q enable → CondEx, Flags.
- The FSM and the ALU decoder stay in mc_controller.

## Test plan
- Reset mid-LDR (in MEMRD) → next cycle FETCH, Flags=0000, no RegWrite pulse.
- ADDS Z-producing (Op=00, Funct=101001, ALUFlags=0100) → 4 cycles, RegWrite in ALUWB, Flags=0100.
- Then BEQ (Cond=0000, Op=10) → PCWrite in BRANCH.
- BNE under the same flags → no PCWrite in BRANCH, back to FETCH after 3 cycles.
- STR (Op=01, Funct[0]=0) → MemWrite=1 only in MEMWR, AdrSrc=1, RegSrc=01.
- LDR to Rd=1111 → PCWrite and RegWrite in MEMWB.
- CMP (cmd 1010, S=1) → RegWrite=0 in ALUWB, flags updated, ALUControl=1.
- EOR with EXT_LOGIC=0 → DECODE→UNDEF, Undef=1 for one cycle, no writes.
- Same EOR with EXT_LOGIC=1 → ALUControl=4.
